// File: rtl/uart_pkg.sv
// Shared UART receiver constants, baud-tick formula and receiver state encoding.
// No logic; latency and backpressure are defined by the modules that import it.
package uart_pkg;

  localparam int BAUDRATE   = 115200;
  localparam int CLOCK_FREQ = 27000000;

  function automatic int baud_ticks(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  localparam int BAUD_TICKS = baud_ticks(CLOCK_FREQ, BAUDRATE);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser with a configurable reset value; 2-cycle latency.
// No backpressure: samples every clock.
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clock,
  input  logic n_reset,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, mid-bit sampling; data_valid ~2 + BAUD_TICKS/2 + 9*BAUD_TICKS cycles after the start edge.
// No backpressure or buffering: each good byte overwrites data_out and pulses data_valid for one cycle.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUDRATE   = uart_pkg::BAUDRATE,
  parameter int CLOCK_FREQ = uart_pkg::CLOCK_FREQ,
  parameter int BAUD_TICKS = uart_pkg::baud_ticks(CLOCK_FREQ, BAUDRATE)
) (
  input  logic       clock,
  input  logic       n_reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_error,
  output logic       rx_busy
);

  localparam int          HALF_TICKS = BAUD_TICKS / 2;
  localparam logic [15:0] LAST_TICK  = 16'(BAUD_TICKS - 1);
  localparam logic [15:0] HALF_LAST  = 16'(HALF_TICKS - 1);

  logic        w_rx_s;
  rx_state_t   r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_ferr;
  logic        r_busy;

  uart_sync #(.RST_VAL(1'b1)) u_sync (
    .clock   (clock),
    .n_reset (n_reset),
    .d       (rx),
    .q       (w_rx_s)
  );

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_data    <= 8'h00;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_rx_s) begin
            r_state <= ST_START;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        // Start bit re-checked at its middle; a high line here was only a glitch.
        ST_START: begin
          if (r_cnt == HALF_LAST) begin
            r_cnt <= '0;
            if (!w_rx_s) begin
              r_state   <= ST_DATA;
              r_bit_idx <= '0;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (r_cnt == LAST_TICK) begin
            r_shift[r_bit_idx] <= w_rx_s;
            r_cnt              <= '0;
            r_bit_idx          <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) r_state <= ST_STOP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_STOP: begin
          if (r_cnt == LAST_TICK) begin
            r_cnt <= '0;
            if (w_rx_s) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= ST_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_BREAK: begin
          if (w_rx_s) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out    = r_data;
  assign data_valid  = r_valid;
  assign frame_error = r_ferr;
  assign rx_busy     = r_busy;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter BAUDRATE, default 115200, meaning serial bit rate in bits/s.
REQ-002 SHALL have parameter CLOCK_FREQ, default 27000000, meaning clock frequency in Hz.
REQ-003 SHALL have parameter BAUD_TICKS, default CLOCK_FREQ/BAUDRATE (234), meaning clock cycles per bit period.
REQ-004 SHALL have port clock, input, 1, sole clock, rising edge.
REQ-005 SHALL have port n_reset, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port rx, input, 1, asynchronous serial line; idle high; 8N1; LSB first.
REQ-007 SHALL have port data_out, output, 8, last correctly framed byte.
REQ-008 SHALL have port data_valid, output, 1, one-cycle pulse when data_out is updated.
REQ-009 SHALL have port frame_error, output, 1, one-cycle pulse when the stop bit samples low.
REQ-010 SHALL have port rx_busy, output, 1, high in every state except IDLE.

Function
REQ-011 SHALL pass rx through a 2-flop synchroniser (reset value 1) to give rx_s; all decisions SHALL use rx_s only.
REQ-012 SHALL implement states IDLE, START, DATA, STOP, BREAK.
REQ-013 IDLE: on rx_s==0, SHALL go to START with the counter at 0.
REQ-014 START: SHALL count to HALF_TICKS-1 (BAUD_TICKS/2, truncated); at that count, rx_s==0 SHALL go to DATA (counter 0, bit_idx 0), and rx_s==1 SHALL return to IDLE as a glitch with no output pulse.
REQ-015 DATA: at counter==BAUD_TICKS-1, SHALL store rx_s into shift[bit_idx] (LSB first), clear the counter and increment bit_idx; after bit_idx 7 it SHALL go to STOP.
REQ-016 STOP: at counter==BAUD_TICKS-1 with rx_s==1, SHALL load data_out<=shift, pulse data_valid and go to IDLE.
REQ-017 STOP: at counter==BAUD_TICKS-1 with rx_s==0, SHALL leave data_out unchanged, pulse frame_error and go to BREAK.
REQ-018 BREAK: SHALL stay until rx_s==1, then go to IDLE; no pulses in BREAK.
REQ-019 Samples SHALL land at mid-bit: the data bit n sample SHALL occur HALF_TICKS + (n+1)*BAUD_TICKS cycles after the start edge is detected on rx_s.
REQ-020 Latency from the rx falling edge to data_valid SHALL be 2 (sync) + HALF_TICKS + 9*BAUD_TICKS cycles, ±1.
REQ-021 data_valid and frame_error SHALL never be high together and SHALL each last exactly one cycle.
REQ-022 SHALL have no buffering; a new byte SHALL overwrite data_out, and the consumer samples it on data_valid.
REQ-023 The next start bit SHALL be accepted in the cycle after the return to IDLE; back-to-back frames SHALL work.
REQ-024 The baud counter SHALL be 16 bits wide and SHALL never wrap while in use; BAUD_TICKS SHALL be in the range 4..65535.
REQ-025 SHALL tolerate a transmitter bit period of BAUD_TICKS±2% without error.

Reset
REQ-026 n_reset low SHALL at once force: state IDLE, counter 0, bit_idx 0, shift 0, data_out 8'h00, data_valid 0, frame_error 0, rx_busy 0, sync flops 1.
REQ-027 Reset during a frame SHALL drop the frame with no pulse; after release, a low rx SHALL be treated as a new start bit.

Structure
REQ-028 Shared package uart_pkg SHALL hold BAUDRATE, CLOCK_FREQ, the BAUD_TICKS formula and the receiver state encoding.
REQ-029 The synchroniser SHALL be a sub-module uart_sync (2 flops, parameter for reset value).

Verification
REQ-030 Byte 8'hA5 at BAUD_TICKS period -> data_valid pulse once, data_out==8'hA5, frame_error never high.
REQ-031 Back-to-back 8'h00 then 8'hFF, with no idle gap -> two data_valid pulses, values 8'h00 then 8'hFF.
REQ-032 rx low pulse of 50 cycles from idle -> return to IDLE, no pulses, rx_busy low again before cycle 120.
REQ-033 Byte 8'h3C with stop bit held low for 3 bit periods -> frame_error pulse once, data_out keeps its old value, state BREAK until rx high, then byte 8'h81 received correctly.
REQ-034 Byte 8'h55 at bit periods of 229 and 239 cycles -> data_out==8'h55 both times.
REQ-035 n_reset low for 5 cycles in the middle of bit 4 of 8'hC3 -> no pulse, data_out==8'h00, next byte 8'h12 received correctly.
